// File: rtl/key_hold_pkg.sv
// key_hold_timer shared types, defaults and tick-period helper.
// Optional auto-repeat is enabled by defining KEY_HOLD_AUTO_REPEAT_EN.
package key_hold_pkg;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_HOLD_TICKS = 50;
  localparam int DEF_CNT_W      = 8;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  function automatic int period_clocks(
    input int clk_hz,
    input int tick_hz,
    input int div
  );
    int p;
    p = 1;
    if (tick_hz > 0 && div > 0)
      p = (clk_hz / tick_hz) / div;
    if (p < 1)
      p = 1;
    return p;
  endfunction

endpackage

// File: rtl/key_hold_if.sv
// key_hold_timer key inputs and per-channel hold status bundle.
// repeat_pulse exists only when KEY_HOLD_AUTO_REPEAT_EN is defined.
interface key_hold_if #(
  parameter int NUM_KEYS = 2,
  parameter int CNT_W    = 8
);

  logic                           turbo;
  logic [NUM_KEYS-1:0]            key_pressed;
  logic [NUM_KEYS-1:0][CNT_W-1:0] hold_ticks;
  logic [NUM_KEYS-1:0]            max_hold;
  logic [NUM_KEYS-1:0]            max_rise;
`ifdef KEY_HOLD_AUTO_REPEAT_EN
  logic [NUM_KEYS-1:0]            repeat_pulse;
`endif

  modport master (
    output turbo,
    output key_pressed,
    input  hold_ticks,
    input  max_hold,
`ifdef KEY_HOLD_AUTO_REPEAT_EN
    input  repeat_pulse,
`endif
    input  max_rise
  );

  modport slave (
    input  turbo,
    input  key_pressed,
    output hold_ticks,
    output max_hold,
`ifdef KEY_HOLD_AUTO_REPEAT_EN
    output repeat_pulse,
`endif
    output max_rise
  );

endinterface

// File: rtl/key_hold_timer_tick_prescaler.sv
// Shared free-running prescaler producing the hold-time tick.
// Compare is >= so switching to the shorter period ticks at once.
module tick_prescaler #(
  parameter int NORM_P  = 10,
  parameter int TURBO_P = 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic turbo,
  output logic tick
);

  localparam int MAXP = (NORM_P > TURBO_P) ? NORM_P : TURBO_P;
  localparam int PW   = $clog2(MAXP + 1);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_lim;

  assign w_lim = turbo ? PW'(TURBO_P - 1) : PW'(NORM_P - 1);
  assign tick  = (r_cnt >= w_lim);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_cnt <= '0;
    else if (tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + PW'(1);
  end

endmodule

// File: rtl/key_hold_timer.sv
// N-channel key-hold duration timer with saturating tick counts.
// Define KEY_HOLD_AUTO_REPEAT_EN to add REPEAT_TICKS and repeat_pulse.
module key_hold_timer
  import key_hold_pkg::*;
#(
  parameter int NUM_KEYS     = 2,
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int TICK_HZ      = 10,
  parameter int TURBO_DIV    = 10,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int CNT_W        = DEF_CNT_W,
`ifdef KEY_HOLD_AUTO_REPEAT_EN
  parameter int REPEAT_TICKS = 5,
`endif
  parameter bit EXCLUSIVE    = 1'b1
) (
  input logic       clk,
  input logic       resetN,
  key_hold_if.slave bus
);

  localparam int NORM_P  = period_clocks(CLK_HZ, TICK_HZ, 1);
  localparam int TURBO_P = period_clocks(CLK_HZ, TICK_HZ, TURBO_DIV);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_TICKS);
  localparam logic [NUM_KEYS-1:0] ONE = NUM_KEYS'(1);

  if (HOLD_TICKS > (2 ** CNT_W) - 1) begin : g_chk
    $error("key_hold_timer: HOLD_TICKS does not fit in CNT_W");
  end

  logic                           w_tick;
  logic [NUM_KEYS-1:0]            w_act;
  logic [NUM_KEYS-1:0][CNT_W-1:0] w_ht;
  logic [NUM_KEYS-1:0]            w_mh;
  logic [NUM_KEYS-1:0]            w_mr;

  tick_prescaler #(
    .NORM_P  (NORM_P),
    .TURBO_P (TURBO_P)
  ) u_presc (
    .clk    (clk),
    .resetN (resetN),
    .turbo  (bus.turbo),
    .tick   (w_tick)
  );

  // Lowest set bit wins when channels are mutually exclusive.
  assign w_act = EXCLUSIVE
    ? (bus.key_pressed & (~bus.key_pressed + ONE))
    : bus.key_pressed;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt;
    logic             r_max;
    logic             r_rise;
    logic             w_max_n;

    always_comb begin
      w_nxt = r_cnt;
      if (!w_act[g])
        w_nxt = '0;
      else if (w_tick)
        w_nxt = (r_cnt >= HOLD) ? HOLD : r_cnt + CNT_W'(1);
    end

    assign w_max_n = w_act[g] && (w_nxt == HOLD);

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_cnt  <= '0;
        r_max  <= 1'b0;
        r_rise <= 1'b0;
      end else begin
        r_cnt  <= w_nxt;
        r_max  <= w_max_n;
        r_rise <= w_max_n & ~r_max;
      end
    end

    assign w_ht[g] = r_cnt;
    assign w_mh[g] = r_max;
    assign w_mr[g] = r_rise;

`ifdef KEY_HOLD_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] r_rep;
    logic          r_rpt;

    // Gating on w_max_n suppresses a pulse on the release edge.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_rep <= '0;
        r_rpt <= 1'b0;
      end else if (!r_max || !w_max_n) begin
        r_rep <= '0;
        r_rpt <= 1'b0;
      end else if (w_tick) begin
        if (r_rep >= RW'(REPEAT_TICKS - 1)) begin
          r_rep <= '0;
          r_rpt <= 1'b1;
        end else begin
          r_rep <= r_rep + RW'(1);
          r_rpt <= 1'b0;
        end
      end else begin
        r_rpt <= 1'b0;
      end
    end

    assign bus.repeat_pulse[g] = r_rpt;
`endif
  end

  assign bus.hold_ticks = w_ht;
  assign bus.max_hold   = w_mh;
  assign bus.max_rise   = w_mr;

endmodule

// File: tb/tb_key_hold_timer.sv
// Directed bench for key_hold_timer: exclusive and independent DUTs.
// Repeat checks are compiled in with KEY_HOLD_AUTO_REPEAT_EN.
module tb_key_hold_timer;
  import key_hold_pkg::*;

  logic clk;
  logic resetN;
  int   n_cmp;
  int   n_bad;

  key_hold_if #(.NUM_KEYS(2), .CNT_W(8)) ifa ();
  key_hold_if #(.NUM_KEYS(2), .CNT_W(8)) ifb ();

  key_hold_timer #(
    .NUM_KEYS     (2),
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .TURBO_DIV    (10),
    .HOLD_TICKS   (5),
    .CNT_W        (8),
`ifdef KEY_HOLD_AUTO_REPEAT_EN
    .REPEAT_TICKS (2),
`endif
    .EXCLUSIVE    (1'b1)
  ) u_a (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifa.slave)
  );

  key_hold_timer #(
    .NUM_KEYS     (2),
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .TURBO_DIV    (10),
    .HOLD_TICKS   (5),
    .CNT_W        (8),
`ifdef KEY_HOLD_AUTO_REPEAT_EN
    .REPEAT_TICKS (2),
`endif
    .EXCLUSIVE    (1'b0)
  ) u_b (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tb;
    logic [1:0]  keys;
    int          n;
    logic [15:0] ht_a;
    logic [1:0]  mh_a;
    logic [1:0]  mr_a;
    logic [15:0] ht_b;
    logic [1:0]  mh_b;
    logic [1:0]  mr_b;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic t, input logic [1:0] k);
    ifa.turbo       = t;
    ifa.key_pressed = k;
    ifb.turbo       = t;
    ifb.key_pressed = k;
  endtask

  function automatic vec_t mk(
    input logic tb, input logic [1:0] k, input int n,
    input logic [7:0] a1, input logic [7:0] a0,
    input logic [1:0] mha, input logic [1:0] mra,
    input logic [7:0] b1, input logic [7:0] b0,
    input logic [1:0] mhb, input logic [1:0] mrb);
    vec_t v;
    v.tb = tb; v.keys = k; v.n = n;
    v.ht_a = {a1, a0}; v.mh_a = mha; v.mr_a = mra;
    v.ht_b = {b1, b0}; v.mh_b = mhb; v.mr_b = mrb;
    return v;
  endfunction

  initial begin
    int k1, k5, rises, maxht;
    n_cmp = 0;
    n_bad = 0;

    vt[0]  = mk(1, 2'b01, 1, 0, 1, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00);
    vt[1]  = mk(1, 2'b01, 3, 0, 4, 2'b00, 2'b00, 0, 4, 2'b00, 2'b00);
    vt[2]  = mk(1, 2'b01, 1, 0, 5, 2'b01, 2'b01, 0, 5, 2'b01, 2'b01);
    vt[3]  = mk(1, 2'b01, 1, 0, 5, 2'b01, 2'b00, 0, 5, 2'b01, 2'b00);
    vt[4]  = mk(1, 2'b11, 1, 0, 5, 2'b01, 2'b00, 1, 5, 2'b01, 2'b00);
    vt[5]  = mk(1, 2'b10, 1, 1, 0, 2'b00, 2'b00, 2, 0, 2'b00, 2'b00);
    vt[6]  = mk(1, 2'b10, 4, 5, 0, 2'b10, 2'b10, 5, 0, 2'b10, 2'b00);
    vt[7]  = mk(1, 2'b11, 1, 0, 1, 2'b00, 2'b00, 5, 1, 2'b10, 2'b00);
    vt[8]  = mk(1, 2'b10, 1, 1, 0, 2'b00, 2'b00, 5, 0, 2'b10, 2'b00);
    vt[9]  = mk(1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00);
    vt[10] = mk(1, 2'b11, 4, 0, 4, 2'b00, 2'b00, 4, 4, 2'b00, 2'b00);
    vt[11] = mk(1, 2'b11, 1, 0, 5, 2'b01, 2'b01, 5, 5, 2'b11, 2'b11);
    vt[12] = mk(1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00);

    resetN = 1'b0;
    drive(1'b1, 2'b00);
    #12;
    chk("rst_ht_a", 32'(ifa.hold_ticks), 0);
    chk("rst_mh_a", 32'(ifa.max_hold), 0);
    chk("rst_mr_a", 32'(ifa.max_rise), 0);
    chk("rst_ht_b", 32'(ifb.hold_ticks), 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].tb, vt[i].keys);
      repeat (vt[i].n) @(negedge clk);
      chk($sformatf("v%0d_ht_a", i), 32'(ifa.hold_ticks), 32'(vt[i].ht_a));
      chk($sformatf("v%0d_mh_a", i), 32'(ifa.max_hold), 32'(vt[i].mh_a));
      chk($sformatf("v%0d_mr_a", i), 32'(ifa.max_rise), 32'(vt[i].mr_a));
      chk($sformatf("v%0d_ht_b", i), 32'(ifb.hold_ticks), 32'(vt[i].ht_b));
      chk($sformatf("v%0d_mh_b", i), 32'(ifb.max_hold), 32'(vt[i].mh_b));
      chk($sformatf("v%0d_mr_b", i), 32'(ifb.max_rise), 32'(vt[i].mr_b));
    end

    // Normal-rate hold: steps every 10 clk, saturates at 5, one rise.
    drive(1'b0, 2'b01);
    k1 = 0; k5 = 0; rises = 0; maxht = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (k1 == 0 && ifa.hold_ticks[0] == 8'd1) k1 = i;
      if (k5 == 0 && ifa.max_hold[0]) k5 = i;
      if (ifa.max_rise[0]) rises++;
      if (int'(ifa.hold_ticks[0]) > maxht) maxht = int'(ifa.hold_ticks[0]);
    end
    chk("norm_first_tick", 32'(k1 >= 1 && k1 <= 10), 1);
    chk("norm_step40", 32'(k5 - k1), 40);
    chk("norm_max_win", 32'(k5 >= 41 && k5 <= 50), 1);
    chk("norm_rises", 32'(rises), 1);
    chk("norm_sat", 32'(maxht), 5);

    // Reset mid-hold: state discarded, counting restarts from zero.
    drive(1'b0, 2'b00);
    @(negedge clk);
    drive(1'b0, 2'b01);
    repeat (30) @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("mid_rst_ht", 32'(ifa.hold_ticks), 0);
    chk("mid_rst_mh", 32'(ifa.max_hold), 0);
    chk("mid_rst_mr", 32'(ifa.max_rise), 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold", 32'(ifa.hold_ticks), 0);
    resetN = 1'b1;
    k5 = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (k5 == 0 && ifa.max_hold[0]) k5 = i;
    end
    chk("post_rst_max_win", 32'(k5 >= 41 && k5 <= 50), 1);
    drive(1'b0, 2'b00);
    @(negedge clk);
    chk("post_rst_rel_ht", 32'(ifa.hold_ticks), 0);
    chk("post_rst_rel_mh", 32'(ifa.max_hold), 0);

`ifdef KEY_HOLD_AUTO_REPEAT_EN
    // Turbo hold of key1: max at 5 clk, repeats at 7, 9, 11.
    drive(1'b1, 2'b10);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      chk($sformatf("rpt_c%0d", i), 32'(ifa.repeat_pulse[1]),
          32'(i >= 7 && (i % 2) == 1));
      if (i == 5) chk("rpt_rise", 32'(ifa.max_rise), 32'(2'b10));
    end
    drive(1'b1, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("rpt_rel%0d", i), 32'(ifa.repeat_pulse), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_hold_timer.md
Name: key_hold_timer

Overview:
- Parametrised N-channel key-hold duration timer; successor to the two-key fixed 5 s rotate-limit counter.
- Per channel: held-time tick count, max-hold flag, one-cycle max-reached pulse.
- Adds configurable threshold, turbo divide factor, and exclusive or independent channel mode.
- Sits between the keypad decoder (synchronised, debounced key levels) and the rod/player movement logic.

Parameters:
- NUM_KEYS, 2, number of key channels.
- CLK_HZ, 50_000_000, system clock frequency. Benches use 100.
- TICK_HZ, 10, hold-time resolution. Normal tick period = CLK_HZ/TICK_HZ clocks.
- TURBO_DIV, 10, tick rate multiplier while turbo=1. Turbo period = CLK_HZ/TICK_HZ/TURBO_DIV clocks, computed at elaboration, minimum 1.
- HOLD_TICKS, 50, ticks held before max_hold asserts (5 s at defaults).
- CNT_W, 8, tick counter width. Elaboration error if HOLD_TICKS > 2**CNT_W-1.
- EXCLUSIVE, 1: only the lowest-index pressed key is active. 0: all channels independent.

Ports:
- clk, in, 1, system clock.
- resetN, in, 1, asynchronous active-low reset.
- turbo, in, 1, selects the turbo tick period.
- key_pressed, in, NUM_KEYS, level per key, already synchronised.
- hold_ticks, out, NUM_KEYS x CNT_W (packed 2-D), current tick count per channel.
- max_hold, out, NUM_KEYS, level; channel has been held HOLD_TICKS ticks.
- max_rise, out, NUM_KEYS, one-cycle pulse on max_hold 0->1.
- repeat_pulse, out, NUM_KEYS, present only under the optional feature.

Behaviour:
- Reset (async, resetN=0): prescaler, all hold_ticks, max_hold, max_rise and repeat_pulse = 0. Reset mid-hold fully discards state. After release, counting restarts from 0 even if the key is still held.
- Prescaler:
  - One shared, free-running counter.
  - Emits tick (1 cycle) when count >= limit-1, then reloads 0. Limit is the normal or turbo period selected by turbo.
  - Compare is >=, so turbo 0->1 mid-period ticks on the next cycle.
  - Turbo 1->0 simply continues counting.
  - First tick after a press arrives 1..period clocks later. This up-to-one-tick jitter is accepted.
- Active set:
  - EXCLUSIVE=1: active = lowest-index bit of key_pressed.
  - EXCLUSIVE=0: active = key_pressed.
- Per channel, at each clk edge:
  - Not active: hold_ticks <= 0, max_hold <= 0. One-cycle latency from release or from losing priority; this matches the old behaviour where pressing one key clears the other's limit.
  - Active and tick: hold_ticks <= sat(hold_ticks+1, HOLD_TICKS). Saturates and never wraps.
  - Active, no tick: hold.
  - max_hold <= (next hold_ticks == HOLD_TICKS). It asserts on the same edge the count reaches HOLD_TICKS.
  - max_rise is high for exactly the one cycle following that edge. It is not re-fired while saturated.
- Simultaneous release and tick: release wins, count goes to 0.
- Priority handover (EXCLUSIVE=1, higher-priority key released while a lower one is held): the lower channel starts from 0 on the next edge.
- HOLD_TICKS=0: max_hold asserts one cycle after activation. max_rise behaves identically.

Optional Feature:
- Macro: KEY_HOLD_AUTO_REPEAT_EN.
- Defined:
  - Parameter REPEAT_TICKS (default 5) and output repeat_pulse are added.
  - While max_hold=1, a per-channel repeat counter counts ticks. repeat_pulse pulses one cycle every REPEAT_TICKS ticks, the first being REPEAT_TICKS ticks after max_rise.
  - The repeat counter clears whenever max_hold=0.
- Undefined: no repeat counters, no repeat_pulse port. Other behaviour is identical.

Decomposition:
- Package key_hold_pkg:
  - Function period_clocks(clk_hz, tick_hz, div), with minimum 1.
  - Typedef for the per-channel count vector.
  - Default constants DEF_CLK_HZ and DEF_HOLD_TICKS.
- Sub-module tick_prescaler (clk, resetN, turbo, tick), parametrised by both periods, instantiated once.
- Per-channel logic is a generate loop in key_hold_timer.

Test Plan (CLK_HZ=100, TICK_HZ=10, TURBO_DIV=10, HOLD_TICKS=5, NUM_KEYS=2):
- Reset during hold: key0 held 30 clk, resetN low 2 clk -> all outputs 0 during reset. After release with key0 still held, max_hold[0] asserts only after 5 fresh ticks (41..50 clk).
- Normal hold: key0 held 60 clk, turbo=0 -> hold_ticks[0] steps every 10 clk. max_hold[0]=1 and max_rise[0] single pulse between clk 41 and 50 after press. Count saturates at 5.
- Turbo: key1 held, turbo=1 -> tick every clock. max_hold[1] at press+5 clk. Release -> both outputs 0 one cycle later.
- Exclusive priority: key1 held to max, then key0 pressed -> max_hold[1], hold_ticks[1] = 0 next cycle, key0 counts. Release key0 -> key1 restarts at 0.
- EXCLUSIVE=0: both keys held -> both reach max_hold in the same cycle, both max_rise pulse together.
- KEY_HOLD_AUTO_REPEAT_EN, REPEAT_TICKS=2, turbo=1: after max_rise, repeat_pulse every 2 clk until release. None after release.
